tff_counter: RTL and testbench

- Parameterised synchronous modulo up/down counter built from per-bit toggle (T) stages, one toggle flip-flop per bit.
- It is the consumer stage for the T flip-flop primitive.
- It is the counting element used for the processor's step/cycle counters and as a cascadable divider.
- It provides parallel load, count enable, direction control, a cascade carry, and a registered wrap pulse.

---
 rtl/tff_counter.sv | 71 +++++++
 tb/tb_tff_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// Synchronous modulo up/down counter built from one toggle flip-flop per bit.
// Offers parallel load, count enable, direction control, a cascade carry (tc) and a registered wrap pulse.
module tff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             at_max;
    logic             at_zero;
    logic             out_of_range;
    logic [WIDTH-1:0] ripple_t;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] load_sat;

    assign at_max       = (count == MAX);
    assign at_zero      = (count == '0);
    assign out_of_range = (count > MAX);
    assign tc           = en & (up ? at_max : at_zero);
    assign load_sat     = (load_val > MAX) ? MAX : load_val;

    // Binary toggle rule: bit i flips when every lower bit is 1 (up) or 0 (down).
    assign ripple_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
        assign ripple_t[i] = ripple_t[i-1] & (up ? count[i-1] : ~count[i-1]);
    end

    // At the terminal count, or from an unreachable state, the toggle vector is
    // forced so the bits land exactly on the wrap target instead of the binary successor.
    always_comb begin
        toggle = '0;
        if (en) begin
            if (tc) begin
                toggle = up ? count : (count ^ MAX);
            end else if (up && out_of_range) begin
                toggle = count;
            end else begin
                toggle = ripple_t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_sat;
            wrap  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (toggle[i]) begin
                    count[i] <= ~count[i];
                end
            end
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: vector table for a modulo-10 counter, plus
// hand-written cascade, power-of-two and modulo-2 sequences.
module tb_tff_counter;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // ---------------- DUT A: WIDTH=4, MODULUS=10 ----------------
    logic       a_clr = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [3:0] a_lv = '0;
    logic [3:0] a_count;
    logic       a_tc, a_wrap;

    tff_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .clr(a_clr), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_lv), .count(a_count), .tc(a_tc), .wrap(a_wrap)
    );

    // ---------------- cascade: two MODULUS=10 stages ----------------
    logic       k_clr = 1'b0, k_en = 1'b0;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, lo_wrap, hi_tc, hi_wrap;

    tff_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk(clk), .clr(k_clr), .en(k_en), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap)
    );
    tff_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .clk(clk), .clr(k_clr), .en(lo_tc), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap)
    );

    // ---------------- DUT P: WIDTH=4, MODULUS=16 ----------------
    logic       p_clr = 1'b0, p_en = 1'b0;
    logic [3:0] p_count;
    logic       p_tc, p_wrap;

    tff_counter #(.WIDTH(4), .MODULUS(16)) dut_p (
        .clk(clk), .clr(p_clr), .en(p_en), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(p_count), .tc(p_tc), .wrap(p_wrap)
    );

    // ---------------- DUT M: WIDTH=1, MODULUS=2 ----------------
    logic m_clr = 1'b0, m_en = 1'b0, m_up = 1'b1;
    logic m_count;
    logic m_tc, m_wrap;

    tff_counter #(.WIDTH(1), .MODULUS(2)) dut_m (
        .clk(clk), .clr(m_clr), .en(m_en), .up(m_up), .load(1'b0),
        .load_val(1'b0), .count(m_count), .tc(m_tc), .wrap(m_wrap)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    typedef struct {
        logic       clr, en, up, load;
        logic [3:0] lv;
        logic [3:0] exp_count;
        logic       exp_tc, exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, en, up, load, input logic [3:0] lv,
                       input logic [3:0] c, input logic t, input logic w);
        vec_t v;
        v.clr = clr; v.en = en; v.up = up; v.load = load; v.lv = lv;
        v.exp_count = c; v.exp_tc = t; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lw, hw, n;
        logic [7:0] e;

        // clr beats load and en together
        add(1, 1, 1, 1, 4'd7, 4'd0, 0, 0);
        // up count across the wrap: 1..9,0,1,2
        for (int i = 1; i <= 12; i++)
            add(0, 1, 1, 0, 4'd0, 4'(i % 10), (i % 10) == 9, i == 10);
        // down wrap from 2: 1,0,9,8
        add(0, 0, 1, 1, 4'd2, 4'd2, 0, 0);
        add(0, 1, 0, 0, 4'd0, 4'd1, 0, 0);
        add(0, 1, 0, 0, 4'd0, 4'd0, 1, 0);
        add(0, 1, 0, 0, 4'd0, 4'd9, 0, 1);
        add(0, 1, 0, 0, 4'd0, 4'd8, 0, 0);
        // load rules, saturation, load beats en
        add(0, 0, 1, 1, 4'd6, 4'd6, 0, 0);
        add(0, 0, 1, 1, 4'd13, 4'd9, 0, 0);
        add(0, 0, 1, 1, 4'd3, 4'd3, 0, 0);
        add(0, 1, 1, 1, 4'd5, 4'd5, 0, 0);
        // hold at 4 then direction flip each edge
        add(0, 0, 1, 1, 4'd4, 4'd4, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 4'd0, 4'd4, 0, 0);
        add(0, 1, 1, 0, 4'd0, 4'd5, 0, 0);
        add(0, 1, 0, 0, 4'd0, 4'd4, 0, 0);
        add(0, 1, 1, 0, 4'd0, 4'd5, 0, 0);
        add(0, 1, 0, 0, 4'd0, 4'd4, 0, 0);
        // at terminal: load with en wins (no wrap), then clr wins (no wrap)
        add(0, 0, 1, 1, 4'd9, 4'd9, 0, 0);
        add(0, 1, 1, 1, 4'd9, 4'd9, 1, 0);
        add(1, 1, 1, 0, 4'd0, 4'd0, 0, 0);
        // down wrap from 0 with en, then a plain up step
        add(0, 1, 0, 0, 4'd0, 4'd9, 0, 1);
        add(0, 1, 1, 0, 4'd0, 4'd0, 0, 1);

        foreach (vecs[i]) begin
            a_clr = vecs[i].clr; a_en = vecs[i].en; a_up = vecs[i].up;
            a_load = vecs[i].load; a_lv = vecs[i].lv;
            step();
            check($sformatf("vec%0d count", i), a_count, vecs[i].exp_count);
            check($sformatf("vec%0d tc", i), a_tc, vecs[i].exp_tc);
            check($sformatf("vec%0d wrap", i), a_wrap, vecs[i].exp_wrap);
        end
        a_en = 1'b0; a_load = 1'b0;

        // cascade: 100 low-stage steps must return to 00
        k_clr = 1'b1;
        step();
        k_clr = 1'b0;
        check("cascade reset", {hi_count, lo_count}, 0);
        k_en = 1'b1;
        lw = 0; hw = 0;
        for (n = 1; n <= 100; n++) begin
            step();
            if (lo_wrap) lw++;
            if (hi_wrap) hw++;
            exp_q.push_back(8'(n % 100));
            e = exp_q.pop_front();
            check($sformatf("cascade n=%0d", n), hi_count * 10 + lo_count, e);
        end
        k_en = 1'b0;
        check("cascade lo wraps", lw, 10);
        check("cascade hi wraps", hw, 1);

        // power-of-two modulus: 16 up steps return to 0
        p_clr = 1'b1;
        step();
        p_clr = 1'b0;
        p_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("mod16 step%0d count", i), p_count, i % 16);
            check($sformatf("mod16 step%0d tc", i), p_tc, i == 15);
            check($sformatf("mod16 step%0d wrap", i), p_wrap, i == 16);
        end
        p_en = 1'b0;

        // modulo 2: alternating direction gives back-to-back wraps
        m_clr = 1'b1;
        step();
        m_clr = 1'b0;
        check("mod2 reset", m_count, 0);
        m_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            m_up = (i % 2 == 0);
            step();
            check($sformatf("mod2 step%0d count", i), m_count, i % 2);
            check($sformatf("mod2 step%0d wrap", i), m_wrap, 1);
        end
        m_en = 1'b0;
        step();
        check("mod2 idle wrap", m_wrap, 0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
